// File: rtl/minn_moving_sum.sv
`default_nettype none
// ============================================================================
//  Module   : minn_moving_sum
//  Purpose  : Sliding-window accumulator for the Minn timing metric. Keeps the
//             running sum of the last WINDOW accepted samples by adding each
//             fresh sample x[n] and subtracting the delayed sample
//             x[n-WINDOW] supplied by the upstream delay line. Emits one
//             full-precision sum per accepted sample once the window is full
//             and raises a sticky flag if the fresh and delayed streams
//             disagree about alignment.
//
//  Ports    : clk        - rising-edge clock
//             rst_n      - asynchronous active-low reset
//             clear      - synchronous restart (window, pipeline, error flag)
//             in_valid   - fresh sample strobe
//             in_data    - fresh sample x[n], signed WIDTH
//             dly_valid  - delayed sample strobe (delay line out_valid)
//             dly_data   - delayed sample x[n-WINDOW], signed WIDTH
//             out_valid  - one-cycle strobe per accepted sample, window full
//             out_sum    - signed OUT_WIDTH sum of the last WINDOW samples
//             out_full   - WINDOW samples accepted since reset/clear
//             err_align  - sticky alignment error
//
//  Revision : 1.0 - initial release
// ============================================================================
module minn_moving_sum #(
    parameter  int WIDTH     = 16,
    parameter  int WINDOW    = 64,
    localparam int OUT_WIDTH = WIDTH + $clog2(WINDOW) + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    input  logic                        in_valid,
    input  logic signed [WIDTH-1:0]     in_data,
    input  logic                        dly_valid,
    input  logic signed [WIDTH-1:0]     dly_data,
    output logic                        out_valid,
    output logic signed [OUT_WIDTH-1:0] out_sum,
    output logic                        out_full,
    output logic                        err_align
);

    localparam int                CNT_W    = $clog2(WINDOW + 1);
    localparam int                EXT_W    = OUT_WIDTH - WIDTH - 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(WINDOW);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WINDOW - 1);

    // Stage 1: difference, its valid, and whether it will produce an output
    logic signed [WIDTH:0]      diff_q,      diff_d;
    logic                       s1_valid_q,  s1_valid_d;
    logic                       s1_emit_q,   s1_emit_d;
    // Fill tracking
    logic [CNT_W-1:0]           fill_cnt_q,  fill_cnt_d;
    // Stage 2: accumulator and output flags
    logic signed [OUT_WIDTH-1:0] acc_q,      acc_d;
    logic                       out_valid_q, out_valid_d;
    logic                       out_full_q,  out_full_d;
    logic                       err_q,       err_d;

    logic                       w_accept;
    logic                       w_at_full;
    logic signed [WIDTH:0]      w_in_ext;
    logic signed [WIDTH:0]      w_dly_ext;
    logic                       w_err_event;

    assign w_accept  = in_valid & ~clear;
    assign w_at_full = (fill_cnt_q == FULL_CNT);
    assign w_in_ext  = {in_data[WIDTH-1], in_data};
    assign w_dly_ext = dly_valid ? {dly_data[WIDTH-1], dly_data} : '0;

    // (a) delayed strobe on a bubble, (b) delayed strobe before the window
    // has filled, (c) missing delayed strobe once the window is full.
    assign w_err_event = (dly_valid & ~in_valid)
                       | (w_accept &  dly_valid & ~w_at_full)
                       | (w_accept & ~dly_valid &  w_at_full);

    always_comb begin
        diff_d      = diff_q;
        s1_valid_d  = 1'b0;
        s1_emit_d   = 1'b0;
        fill_cnt_d  = fill_cnt_q;
        acc_d       = acc_q;
        out_valid_d = 1'b0;
        // Registered from the count so it rises together with the first
        // out_valid, one edge after the WINDOW-th sample is accepted.
        out_full_d  = w_at_full;
        err_d       = err_q | w_err_event;

        if (w_accept) begin
            diff_d     = w_in_ext - w_dly_ext;
            s1_valid_d = 1'b1;
            // This sample completes the window or arrives after it filled.
            s1_emit_d  = w_at_full | (fill_cnt_q == LAST_CNT);
            if (!w_at_full) begin
                fill_cnt_d = fill_cnt_q + 1'b1;
            end
        end

        if (s1_valid_q) begin
            acc_d       = acc_q + {{EXT_W{diff_q[WIDTH]}}, diff_q};
            out_valid_d = s1_emit_q;
        end

        // Clear wins over everything, including the sample in flight.
        if (clear) begin
            diff_d      = '0;
            s1_valid_d  = 1'b0;
            s1_emit_d   = 1'b0;
            fill_cnt_d  = '0;
            acc_d       = '0;
            out_valid_d = 1'b0;
            out_full_d  = 1'b0;
            err_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_q      <= '0;
            s1_valid_q  <= 1'b0;
            s1_emit_q   <= 1'b0;
            fill_cnt_q  <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_full_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            diff_q      <= diff_d;
            s1_valid_q  <= s1_valid_d;
            s1_emit_q   <= s1_emit_d;
            fill_cnt_q  <= fill_cnt_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_full_q  <= out_full_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = acc_q;
    assign out_full  = out_full_q;
    assign err_align = err_q;

endmodule
`default_nettype wire

// File: tb/tb_minn_moving_sum.sv
`default_nettype none
// ============================================================================
//  Module   : tb_minn_moving_sum
//  Purpose  : Directed self-checking bench for minn_moving_sum. Instance A
//             uses WINDOW=4 for ramp, bubble, clear, alignment and reset
//             scenarios; instance B uses WINDOW=64 for the extreme-value case.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_minn_moving_sum;

    localparam int W   = 16;
    localparam int WA  = 4;
    localparam int WB  = 64;
    localparam int OWA = W + $clog2(WA) + 1;
    localparam int OWB = W + $clog2(WB) + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                  a_clear, a_in_valid, a_dly_valid;
    logic signed [W-1:0]   a_in_data, a_dly_data;
    logic                  a_out_valid, a_out_full, a_err_align;
    logic signed [OWA-1:0] a_out_sum;

    logic                  b_clear, b_in_valid, b_dly_valid;
    logic signed [W-1:0]   b_in_data, b_dly_data;
    logic                  b_out_valid, b_out_full, b_err_align;
    logic signed [OWB-1:0] b_out_sum;

    minn_moving_sum #(.WIDTH(W), .WINDOW(WA)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .clear(a_clear),
        .in_valid(a_in_valid), .in_data(a_in_data),
        .dly_valid(a_dly_valid), .dly_data(a_dly_data),
        .out_valid(a_out_valid), .out_sum(a_out_sum),
        .out_full(a_out_full), .err_align(a_err_align)
    );

    minn_moving_sum #(.WIDTH(W), .WINDOW(WB)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .clear(b_clear),
        .in_valid(b_in_valid), .in_data(b_in_data),
        .dly_valid(b_dly_valid), .dly_data(b_dly_data),
        .out_valid(b_out_valid), .out_sum(b_out_sum),
        .out_full(b_out_full), .err_align(b_err_align)
    );

    int checks = 0;
    int errors = 0;

    // Output monitor for instance A, filled by cyc_a
    int                    got_n;
    logic signed [OWA-1:0] got_sum [8];
    logic                  got_full [8];
    bit                    bad_bubble, early_full, last_acc;

    int exp_ramp [3] = '{10, 14, 18};

    task automatic reset_mon();
        got_n      = 0;
        bad_bubble = 1'b0;
        early_full = 1'b0;
        for (int k = 0; k < 8; k++) begin
            got_sum[k]  = 'x;
            got_full[k] = 1'bx;
        end
    endtask

    // One clock on instance A; records out_valid pulses seen after the edge.
    task automatic cyc_a(input logic v, input int d, input logic dv, input int dd, input logic clr);
        a_in_valid  = v;
        a_in_data   = W'(d);
        a_dly_valid = dv;
        a_dly_data  = W'(dd);
        a_clear     = clr;
        @(posedge clk);
        #1;
        if (a_out_valid) begin
            if (!last_acc) bad_bubble = 1'b1;
            if (got_n < 8) begin
                got_sum[got_n]  = a_out_sum;
                got_full[got_n] = a_out_full;
            end
            got_n++;
        end else if (a_out_full && got_n == 0) begin
            early_full = 1'b1;
        end
        last_acc    = v && !clr;
        a_in_valid  = 1'b0;
        a_dly_valid = 1'b0;
        a_clear     = 1'b0;
    endtask

    task automatic cyc_b(input logic v, input int d, input logic dv, input int dd, input logic clr);
        b_in_valid  = v;
        b_in_data   = W'(d);
        b_dly_valid = dv;
        b_dly_data  = W'(dd);
        b_clear     = clr;
        @(posedge clk);
        #1;
        b_in_valid  = 1'b0;
        b_dly_valid = 1'b0;
        b_clear     = 1'b0;
    endtask

    // Ramp x = 1..6 with dly_data = x delayed by 4, optional bubbles between.
    task automatic ramp_feed(input bit bubbles);
        reset_mon();
        for (int i = 1; i <= 6; i++) begin
            if (bubbles) cyc_a(1'b0, 0, 1'b0, 0, 1'b0);
            cyc_a(1'b1, i, (i >= 5), (i >= 5) ? i - 4 : 0, 1'b0);
        end
        repeat (3) cyc_a(1'b0, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_reset();
        a_clear = 0; a_in_valid = 0; a_dly_valid = 0; a_in_data = 0; a_dly_data = 0;
        b_clear = 0; b_in_valid = 0; b_dly_valid = 0; b_in_data = 0; b_dly_data = 0;
        last_acc = 1'b0;
        reset_mon();
        #12;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", a_out_valid); end
        checks++; if (a_out_sum !== '0) begin errors++; $display("FAIL reset_sum got %0d want 0", a_out_sum); end
        checks++; if (a_out_full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b want 0", a_out_full); end
        checks++; if (a_err_align !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", a_err_align); end
        checks++; if (b_out_sum !== '0) begin errors++; $display("FAIL reset_sum_b got %0d want 0", b_out_sum); end
        @(negedge clk);
        rst_n = 1'b1;
        cyc_a(1'b0, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_ramp();
        ramp_feed(1'b0);
        checks++; if (got_n !== 3) begin errors++; $display("FAIL ramp_count got %0d want 3", got_n); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (got_sum[k] !== exp_ramp[k]) begin errors++; $display("FAIL ramp_sum%0d got %0d want %0d", k, got_sum[k], exp_ramp[k]); end
        end
        checks++; if (got_full[0] !== 1'b1 || early_full) begin errors++; $display("FAIL ramp_full got %0b early %0b want 1 early 0", got_full[0], early_full); end
        checks++; if (a_err_align !== 1'b0) begin errors++; $display("FAIL ramp_err got %0b want 0", a_err_align); end
        cyc_a(1'b0, 0, 1'b0, 0, 1'b1);
    endtask

    task automatic test_bubbles();
        ramp_feed(1'b1);
        checks++; if (got_n !== 3) begin errors++; $display("FAIL bub_count got %0d want 3", got_n); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (got_sum[k] !== exp_ramp[k]) begin errors++; $display("FAIL bub_sum%0d got %0d want %0d", k, got_sum[k], exp_ramp[k]); end
        end
        checks++; if (bad_bubble) begin errors++; $display("FAIL bub_valid got valid-on-bubble want none"); end
        checks++; if (a_err_align !== 1'b0) begin errors++; $display("FAIL bub_err got %0b want 0", a_err_align); end
        cyc_a(1'b0, 0, 1'b0, 0, 1'b1);
    endtask

    task automatic test_clear();
        reset_mon();
        for (int i = 1; i <= 4; i++) cyc_a(1'b1, i, 1'b0, 0, 1'b0);
        cyc_a(1'b1, 5, 1'b1, 1, 1'b1);
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL clr_valid got %0b want 0", a_out_valid); end
        checks++; if (a_out_sum !== '0) begin errors++; $display("FAIL clr_sum got %0d want 0", a_out_sum); end
        checks++; if (a_out_full !== 1'b0) begin errors++; $display("FAIL clr_full got %0b want 0", a_out_full); end
        checks++; if (got_n !== 0) begin errors++; $display("FAIL clr_early got %0d pulses want 0", got_n); end
        for (int i = 7; i <= 10; i++) cyc_a(1'b1, i, 1'b0, 0, 1'b0);
        repeat (2) cyc_a(1'b0, 0, 1'b0, 0, 1'b0);
        checks++; if (got_n !== 1 || got_sum[0] !== 34) begin errors++; $display("FAIL clr_refill got n=%0d sum=%0d want n=1 sum=34", got_n, got_sum[0]); end
        checks++; if (a_err_align !== 1'b0 || a_out_full !== 1'b1) begin errors++; $display("FAIL clr_flags got err=%0b full=%0b want err=0 full=1", a_err_align, a_out_full); end
        cyc_a(1'b0, 0, 1'b0, 0, 1'b1);
    endtask

    task automatic test_align();
        // (i) delayed strobe on sample 2 of a fill
        cyc_a(1'b1, 1, 1'b0, 0, 1'b0);
        checks++; if (a_err_align !== 1'b0) begin errors++; $display("FAIL al1_pre got %0b want 0", a_err_align); end
        cyc_a(1'b1, 2, 1'b1, 0, 1'b0);
        checks++; if (a_err_align !== 1'b1) begin errors++; $display("FAIL al1_set got %0b want 1", a_err_align); end
        repeat (3) cyc_a(1'b0, 0, 1'b0, 0, 1'b0);
        checks++; if (a_err_align !== 1'b1) begin errors++; $display("FAIL al1_hold got %0b want 1", a_err_align); end
        cyc_a(1'b0, 0, 1'b0, 0, 1'b1);
        checks++; if (a_err_align !== 1'b0) begin errors++; $display("FAIL al1_clr got %0b want 0", a_err_align); end
        // (ii) missing delayed strobe on sample 5
        for (int i = 1; i <= 4; i++) cyc_a(1'b1, i, 1'b0, 0, 1'b0);
        checks++; if (a_err_align !== 1'b0) begin errors++; $display("FAIL al2_pre got %0b want 0", a_err_align); end
        cyc_a(1'b1, 5, 1'b0, 0, 1'b0);
        checks++; if (a_err_align !== 1'b1) begin errors++; $display("FAIL al2_set got %0b want 1", a_err_align); end
        repeat (3) cyc_a(1'b0, 0, 1'b0, 0, 1'b0);
        checks++; if (a_err_align !== 1'b1) begin errors++; $display("FAIL al2_hold got %0b want 1", a_err_align); end
        cyc_a(1'b0, 0, 1'b0, 0, 1'b1);
        // (iii) delayed strobe on a bubble
        cyc_a(1'b0, 0, 1'b1, 5, 1'b0);
        checks++; if (a_err_align !== 1'b1) begin errors++; $display("FAIL al3_set got %0b want 1", a_err_align); end
        cyc_a(1'b0, 0, 1'b0, 0, 1'b0);
        checks++; if (a_err_align !== 1'b1) begin errors++; $display("FAIL al3_hold got %0b want 1", a_err_align); end
        cyc_a(1'b0, 0, 1'b0, 0, 1'b1);
        checks++; if (a_err_align !== 1'b0) begin errors++; $display("FAIL al3_clr got %0b want 0", a_err_align); end
    endtask

    task automatic test_extremes();
        for (int i = 0; i < WB; i++) cyc_b(1'b1, -32768, 1'b0, 0, 1'b0);
        cyc_b(1'b0, 0, 1'b0, 0, 1'b0);
        checks++; if (b_out_sum !== -2097152) begin errors++; $display("FAIL ext_neg got %0d want -2097152", b_out_sum); end
        checks++; if (b_out_valid !== 1'b1 || b_out_full !== 1'b1) begin errors++; $display("FAIL ext_flags got valid=%0b full=%0b want 1 1", b_out_valid, b_out_full); end
        for (int i = 0; i < WB; i++) cyc_b(1'b1, 32767, 1'b1, -32768, 1'b0);
        cyc_b(1'b0, 0, 1'b0, 0, 1'b0);
        checks++; if (b_out_sum !== 2097088) begin errors++; $display("FAIL ext_pos got %0d want 2097088", b_out_sum); end
        checks++; if (b_err_align !== 1'b0) begin errors++; $display("FAIL ext_err got %0b want 0", b_err_align); end
    endtask

    task automatic test_async_reset();
        reset_mon();
        for (int i = 1; i <= 5; i++) cyc_a(1'b1, i, (i >= 5), (i >= 5) ? i - 4 : 0, 1'b0);
        checks++; if (a_out_sum !== 10 || a_out_valid !== 1'b1) begin errors++; $display("FAIL ar_pre got sum=%0d valid=%0b want 10 1", a_out_sum, a_out_valid); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got %0b want 0", a_out_valid); end
        checks++; if (a_out_sum !== '0) begin errors++; $display("FAIL ar_sum got %0d want 0", a_out_sum); end
        checks++; if (a_out_full !== 1'b0) begin errors++; $display("FAIL ar_full got %0b want 0", a_out_full); end
        checks++; if (b_out_sum !== '0 || b_out_full !== 1'b0) begin errors++; $display("FAIL ar_b got sum=%0d full=%0b want 0 0", b_out_sum, b_out_full); end
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        last_acc = 1'b0;
        ramp_feed(1'b0);
        checks++; if (got_n !== 3) begin errors++; $display("FAIL ar_count got %0d want 3", got_n); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (got_sum[k] !== exp_ramp[k]) begin errors++; $display("FAIL ar_sum%0d got %0d want %0d", k, got_sum[k], exp_ramp[k]); end
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_bubbles();
        test_clear();
        test_align();
        test_extremes();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
